// File: rtl/uartprobe_wide_if.sv
// UART byte channel plus single-beat AXI master signals of the debug probe.
interface uartprobe_wide_if #(
    parameter int DATA_BYTES = 4
) ();
    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic                    rx_ready;
    logic                    tx_valid;
    logic [7:0]              tx_data;
    logic                    tx_ready;
    logic [31:0]             m_axi_araddr;
    logic [2:0]              m_axi_arsize;
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;
    logic [8*DATA_BYTES-1:0] m_axi_rdata;
    logic [1:0]              m_axi_rresp;
    logic                    m_axi_rvalid;
    logic                    m_axi_rready;
    logic [31:0]             m_axi_awaddr;
    logic [2:0]              m_axi_awsize;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [8*DATA_BYTES-1:0] m_axi_wdata;
    logic [DATA_BYTES-1:0]   m_axi_wstrb;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        output rx_ready, tx_valid, tx_data,
        output m_axi_araddr, m_axi_arsize, m_axi_arvalid, input m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready,
        output m_axi_awaddr, m_axi_awsize, m_axi_awvalid, input m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid, output m_axi_bready
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  rx_ready, tx_valid, tx_data,
        input  m_axi_araddr, m_axi_arsize, m_axi_arvalid, output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready,
        input  m_axi_awaddr, m_axi_awsize, m_axi_awvalid, output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid, input m_axi_bready
    );
endinterface

// File: rtl/uartprobe_wide.sv
// UART debug probe: byte-stream command decoder driving GPO/GPI and single-beat AXI accesses.
//
// state     | meaning
// S_IDLE    | waiting for a command byte
// S_RX_ARG  | collecting argument bytes into the shadow register
// S_TX_RESP | shifting response bytes out on the TX channel
// S_AR      | read address presented, waiting for arready
// S_R       | waiting for read data
// S_AWW     | write address and data presented, each waits for its own ready
// S_B       | waiting for write response
module uartprobe_wide #(
    parameter int                        GPIO_BYTES    = 4,
    parameter int                        DATA_BYTES    = 4,
    parameter logic [8*GPIO_BYTES-1:0]   GPO_ON_RESET  = {GPIO_BYTES{8'hA5}},
    parameter logic [31:0]               ADDR_ON_RESET = 32'h0
) (
    input  logic                    clk,
    input  logic                    m_aresetn,
    uartprobe_wide_if.master        bus,
    output logic [8*GPIO_BYTES-1:0] gpo,
    input  logic [8*GPIO_BYTES-1:0] gpi
);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int MAX_A = (GPIO_BYTES > DATA_BYTES) ? GPIO_BYTES : DATA_BYTES;
    localparam int ARG_B = (MAX_A > 4) ? MAX_A : 4;
    localparam int MAX_T = (GPIO_BYTES > DATA_BYTES + 1) ? GPIO_BYTES : DATA_BYTES + 1;
    localparam int TX_W  = 8 * ((MAX_T > 4) ? MAX_T : 4);

    typedef enum logic [2:0] {S_IDLE, S_RX_ARG, S_TX_RESP, S_AR, S_R, S_AWW, S_B} state_t;

    state_t              state;
    logic [7:0]          cmd;
    logic [3:0]          cnt;
    logic [8*ARG_B-1:0]  arg;
    logic [TX_W-1:0]     tx_sh;
    logic [31:0]         addr;
    logic                ae;
    logic [DW-1:0]       wdata;
    logic rx_ready_q, tx_valid_q, arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

    logic [3:0]          arg_len;
    logic [3:0]          arg_idx;
    logic [8*ARG_B-1:0]  arg_nxt;
    logic                rx_hs, tx_hs;

    assign rx_hs = bus.rx_valid && rx_ready_q;
    assign tx_hs = tx_valid_q && bus.tx_ready;

    // Bytes land at their LSB-first position; commits read arg_nxt so the last byte is included.
    always_comb begin
        case (cmd)
            8'h03:   arg_len = 4'(GPIO_BYTES);
            8'h04:   arg_len = 4'd4;
            8'h07:   arg_len = 4'(DATA_BYTES);
            default: arg_len = 4'd1;
        endcase
        arg_idx = arg_len - cnt;
        arg_nxt = arg;
        for (int i = 0; i < ARG_B; i++) begin
            if (arg_idx == 4'(i)) arg_nxt[8*i +: 8] = bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            state      <= S_IDLE;
            cmd        <= 8'h00;
            cnt        <= 4'd0;
            arg        <= '0;
            tx_sh      <= '0;
            addr       <= ADDR_ON_RESET;
            ae         <= 1'b1;
            wdata      <= '0;
            gpo        <= GPO_ON_RESET;
            rx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (rx_hs) begin
                    // Default is a one-byte NAK response; known commands override below.
                    cmd        <= bus.rx_data;
                    rx_ready_q <= 1'b0;
                    tx_valid_q <= 1'b1;
                    state      <= S_TX_RESP;
                    cnt        <= 4'd1;
                    tx_sh      <= TX_W'(8'hEE);
                    case (bus.rx_data)
                        8'h01: begin tx_sh <= TX_W'(gpi);  cnt <= 4'(GPIO_BYTES); end
                        8'h02: begin tx_sh <= TX_W'(gpo);  cnt <= 4'(GPIO_BYTES); end
                        8'h05: begin tx_sh <= TX_W'(addr); cnt <= 4'd4; end
                        8'h09: tx_sh <= TX_W'({7'b0, ae});
                        8'h03, 8'h04, 8'h07, 8'h08: begin
                            rx_ready_q <= 1'b1;
                            tx_valid_q <= 1'b0;
                            state      <= S_RX_ARG;
                            cnt        <= (bus.rx_data == 8'h03) ? 4'(GPIO_BYTES) :
                                          (bus.rx_data == 8'h04) ? 4'd4 :
                                          (bus.rx_data == 8'h07) ? 4'(DATA_BYTES) : 4'd1;
                        end
                        8'h06: begin
                            tx_valid_q <= 1'b0;
                            arvalid_q  <= 1'b1;
                            state      <= S_AR;
                        end
                        default: ;
                    endcase
                end
                S_RX_ARG: if (rx_hs) begin
                    arg <= arg_nxt;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_IDLE;
                        case (cmd)
                            8'h03: gpo  <= arg_nxt[8*GPIO_BYTES-1:0];
                            8'h04: addr <= arg_nxt[31:0];
                            8'h08: ae   <= arg_nxt[0];
                            8'h07: begin
                                wdata      <= arg_nxt[DW-1:0];
                                rx_ready_q <= 1'b0;
                                awvalid_q  <= 1'b1;
                                wvalid_q   <= 1'b1;
                                state      <= S_AWW;
                            end
                            default: ;
                        endcase
                    end
                end
                S_TX_RESP: if (tx_hs) begin
                    tx_sh <= tx_sh >> 8;
                    cnt   <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        tx_valid_q <= 1'b0;
                        rx_ready_q <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_AR: if (bus.m_axi_arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state     <= S_R;
                end
                S_R: if (bus.m_axi_rvalid) begin
                    rready_q   <= 1'b0;
                    tx_sh      <= TX_W'({6'b0, bus.m_axi_rresp, bus.m_axi_rdata});
                    cnt        <= 4'(DATA_BYTES + 1);
                    tx_valid_q <= 1'b1;
                    state      <= S_TX_RESP;
                    if (ae) addr <= addr + 32'(DATA_BYTES);
                end
                S_AWW: begin
                    if (bus.m_axi_awready) awvalid_q <= 1'b0;
                    if (bus.m_axi_wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || bus.m_axi_awready) && (!wvalid_q || bus.m_axi_wready)) begin
                        bready_q <= 1'b1;
                        state    <= S_B;
                    end
                end
                S_B: if (bus.m_axi_bvalid) begin
                    bready_q   <= 1'b0;
                    tx_sh      <= TX_W'({6'b0, bus.m_axi_bresp});
                    cnt        <= 4'd1;
                    tx_valid_q <= 1'b1;
                    state      <= S_TX_RESP;
                    if (ae) addr <= addr + 32'(DATA_BYTES);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready      = rx_ready_q;
    assign bus.tx_valid      = tx_valid_q;
    assign bus.tx_data       = tx_sh[7:0];
    assign bus.m_axi_araddr  = addr;
    assign bus.m_axi_arsize  = 3'($clog2(DATA_BYTES));
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
    assign bus.m_axi_awaddr  = addr;
    assign bus.m_axi_awsize  = 3'($clog2(DATA_BYTES));
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata;
    assign bus.m_axi_wstrb   = '1;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
endmodule

// File: tb/tb_uartprobe_wide.sv
// Randomised bench for uartprobe_wide against a byte-level protocol model.
module tb_uartprobe_wide;
    localparam int GB = 4;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic m_aresetn = 1'b0;
    logic [8*GB-1:0] gpo;
    logic [8*GB-1:0] gpi = '0;
    always #5 clk = ~clk;

    uartprobe_wide_if #(.DATA_BYTES(DB)) bus ();

    uartprobe_wide #(.GPIO_BYTES(GB), .DATA_BYTES(DB)) dut (
        .clk       (clk),
        .m_aresetn (m_aresetn),
        .bus       (bus),
        .gpo       (gpo),
        .gpi       (gpi)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_gpo, m_addr;
    logic        m_ae;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.rx_valid = 0; bus.rx_data = 0; bus.tx_ready = 0;
        bus.m_axi_arready = 0; bus.m_axi_rdata = 0; bus.m_axi_rresp = 0; bus.m_axi_rvalid = 0;
        bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bresp = 0; bus.m_axi_bvalid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        m_aresetn = 0;
        clear_inputs();
        repeat (3) @(negedge clk);
        m_aresetn = 1;
        m_gpo = 32'hA5A5A5A5; m_addr = 32'h0; m_ae = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.rx_valid = 1; bus.rx_data = b;
        while (!bus.rx_ready && n < 200) begin @(negedge clk); n++; end
        chk("rx_ready_seen", bus.rx_ready, 1);
        @(negedge clk);
        bus.rx_valid = 0;
    endtask

    task automatic recv_byte(output logic [7:0] b, input int stall);
        int n = 0;
        logic [7:0] d0;
        logic ok;
        @(negedge clk);
        while (!bus.tx_valid && n < 200) begin @(negedge clk); n++; end
        chk("tx_valid_seen", bus.tx_valid, 1);
        d0 = bus.tx_data; ok = 1;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (!bus.tx_valid || bus.tx_data !== d0 || bus.rx_ready !== 1'b0) ok = 0;
        end
        if (stall > 0) chk("tx_hold_stable", ok, 1);
        bus.tx_ready = 1; b = bus.tx_data;
        @(negedge clk);
        bus.tx_ready = 0;
    endtask

    // One complete command: model predicts response bytes, bench drives UART and AXI sides.
    task automatic do_cmd(input logic [7:0] c, input logic [63:0] arg, input int stall = 0,
                          input int ar_dly = 0, input int aw_dly = 0, input int w_dly = 0,
                          input int resp_dly = 0, input logic [31:0] rdata = 0,
                          input logic [1:0] resp = 0);
        logic [7:0] q[$];
        logic [7:0] b;
        logic [31:0] a0, g0;
        int nargs, n, hold;
        logic ok;
        a0 = m_addr; g0 = m_gpo;
        nargs = (c == 8'h03) ? GB : (c == 8'h04) ? 4 : (c == 8'h07) ? DB : (c == 8'h08) ? 1 : 0;
        case (c)
            8'h01: for (int i = 0; i < GB; i++) q.push_back(gpi[8*i +: 8]);
            8'h02: for (int i = 0; i < GB; i++) q.push_back(m_gpo[8*i +: 8]);
            8'h03: m_gpo = arg[31:0];
            8'h04: m_addr = arg[31:0];
            8'h05: for (int i = 0; i < 4; i++) q.push_back(m_addr[8*i +: 8]);
            8'h06: begin
                for (int i = 0; i < DB; i++) q.push_back(rdata[8*i +: 8]);
                q.push_back({6'b0, resp});
                if (m_ae) m_addr = m_addr + DB;
            end
            8'h07: begin
                q.push_back({6'b0, resp});
                if (m_ae) m_addr = m_addr + DB;
            end
            8'h08: m_ae = arg[0];
            8'h09: q.push_back({7'b0, m_ae});
            default: q.push_back(8'hEE);
        endcase

        send_byte(c);
        for (int i = 0; i < nargs; i++) begin
            send_byte(arg[8*i +: 8]);
            if (c == 8'h03 && i == GB - 2) chk("gpo_no_partial", gpo, g0);
        end

        if (c == 8'h06) begin
            n = 0;
            while (!bus.m_axi_arvalid && n < 100) begin @(negedge clk); n++; end
            chk("arvalid_seen", bus.m_axi_arvalid, 1);
            chk("araddr", bus.m_axi_araddr, a0);
            chk("arsize", bus.m_axi_arsize, 2);
            hold = 1;
            for (int k = 0; k < ar_dly; k++) begin
                @(negedge clk);
                if (bus.m_axi_arvalid) hold++;
            end
            bus.m_axi_arready = 1;
            @(negedge clk);
            bus.m_axi_arready = 0;
            chk("arvalid_hold_cycles", hold, ar_dly + 1);
            chk("arvalid_drop", bus.m_axi_arvalid, 0);
            chk("rready_up", bus.m_axi_rready, 1);
            repeat (resp_dly) @(negedge clk);
            bus.m_axi_rvalid = 1; bus.m_axi_rdata = rdata; bus.m_axi_rresp = resp;
            @(negedge clk);
            bus.m_axi_rvalid = 0;
            chk("rready_drop", bus.m_axi_rready, 0);
        end

        if (c == 8'h07) begin
            chk("awvalid_start", bus.m_axi_awvalid, 1);
            chk("wvalid_start", bus.m_axi_wvalid, 1);
            chk("awaddr", bus.m_axi_awaddr, a0);
            chk("wdata", bus.m_axi_wdata, arg[31:0]);
            chk("wstrb", bus.m_axi_wstrb, 4'hF);
            chk("awsize", bus.m_axi_awsize, 2);
            ok = 1;
            for (int k = 0; k <= ((aw_dly > w_dly) ? aw_dly : w_dly); k++) begin
                if (bus.m_axi_awvalid !== (k <= aw_dly)) ok = 0;
                if (bus.m_axi_wvalid !== (k <= w_dly)) ok = 0;
                if (bus.m_axi_bready !== 1'b0) ok = 0;
                bus.m_axi_awready = (k == aw_dly);
                bus.m_axi_wready = (k == w_dly);
                @(negedge clk);
            end
            bus.m_axi_awready = 0; bus.m_axi_wready = 0;
            chk("aw_w_independent", ok, 1);
            chk("aw_w_dropped", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 2'b00);
            chk("bready_up", bus.m_axi_bready, 1);
            repeat (resp_dly) @(negedge clk);
            bus.m_axi_bvalid = 1; bus.m_axi_bresp = resp;
            @(negedge clk);
            bus.m_axi_bvalid = 0;
            chk("bready_drop", bus.m_axi_bready, 0);
        end

        foreach (q[i]) begin
            recv_byte(b, stall);
            chk($sformatf("tx_byte_c%0h_%0d", c, i), b, q[i]);
        end
        chk("idle_rx_ready", bus.rx_ready, 1);
        chk("idle_tx_valid", bus.tx_valid, 0);
        chk("gpo_model", gpo, m_gpo);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        int r;
        clear_inputs();
        do_reset();
        chk("reset_rx_ready", bus.rx_ready, 1);
        chk("reset_tx_valid", bus.tx_valid, 0);
        chk("reset_axi_valids", {bus.m_axi_arvalid, bus.m_axi_awvalid, bus.m_axi_wvalid,
                                 bus.m_axi_rready, bus.m_axi_bready}, 5'b0);
        chk("reset_gpo", gpo, 32'hA5A5A5A5);
        chk("reset_wdata", bus.m_axi_wdata, 32'h0);

        do_cmd(8'h02, 64'h0);
        do_cmd(8'h03, 64'h44332211);
        chk("gpo_written", gpo, 32'h44332211);
        do_cmd(8'h04, 64'hFFFFFFFC);
        do_cmd(8'h07, 64'hEFBEADDE, 0, 0, 0, 3, 1, 32'h0, 2'd0);
        do_cmd(8'h05, 64'h0);
        do_cmd(8'h08, 64'h00);
        do_cmd(8'h06, 64'h0, 0, 5, 0, 0, 2, 32'h12345678, 2'd2);
        do_cmd(8'h05, 64'h0);
        do_cmd(8'h06, 64'h0, 10, 1, 0, 0, 0, 32'hCAFEF00D, 2'd1);
        do_cmd(8'h09, 64'h0);
        do_cmd(8'h7F, 64'h0);
        @(negedge clk); gpi = 32'h0A0B0C0D;
        do_cmd(8'h01, 64'h0);

        send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        do_reset();
        chk("midreset_gpo", gpo, 32'hA5A5A5A5);
        chk("midreset_rx_ready", bus.rx_ready, 1);
        chk("midreset_tx_valid", bus.tx_valid, 0);
        do_cmd(8'h05, 64'h0);
        do_cmd(8'h09, 64'h0);

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 10);
            c = (r == 10) ? 8'($urandom_range(10, 255)) : 8'(r);
            @(negedge clk); gpi = $urandom;
            do_cmd(c, {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                   $urandom, 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uartprobe_wide.md
Name: uartprobe_wide

Overview:
- Second-generation UART debug probe. Decodes a byte-stream command protocol from a UART RX/TX byte channel.
- Drives a parametrised-width GPO register, samples a parametrised-width GPI bus, and masters single-beat AXI reads and writes of parametrised data width.
- Sits between the UART core's byte handshake interface and an AXI interconnect.
- Additions over the previous generation:
  - multi-byte atomic argument framing;
  - full AXI valid/ready holding, with AW and W completing independently;
  - response-status bytes returned to the host;
  - address auto-increment by the data width;
  - NAK on unknown commands.

Parameters:
- GPIO_BYTES, 4: width of gpo/gpi in bytes (1..8).
- DATA_BYTES, 4: AXI data width in bytes; legal values 1, 2, 4, 8.
- GPO_ON_RESET, {GPIO_BYTES{8'hA5}}: gpo value after reset.
- ADDR_ON_RESET, 32'h0: AXI address register value after reset.

Ports:
- clk  in  1  clock.
- m_aresetn  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  UART RX byte available.
- rx_data  in  8  UART RX byte.
- rx_ready  out  1  probe accepts the RX byte.
- tx_valid  out  1  probe presents a TX byte.
- tx_data  out  8  TX byte.
- tx_ready  in  1  UART TX accepts the byte.
- gpo  out  8*GPIO_BYTES  general-purpose outputs.
- gpi  in  8*GPIO_BYTES  general-purpose inputs.
- m_axi_araddr  out  32 / m_axi_arsize  out  3 / m_axi_arvalid  out  1 / m_axi_arready  in  1.
- m_axi_rdata  in  8*DATA_BYTES / m_axi_rresp  in  2 / m_axi_rvalid  in  1 / m_axi_rready  out  1.
- m_axi_awaddr  out  32 / m_axi_awsize  out  3 / m_axi_awvalid  out  1 / m_axi_awready  in  1.
- m_axi_wdata  out  8*DATA_BYTES / m_axi_wstrb  out  DATA_BYTES / m_axi_wvalid  out  1 / m_axi_wready  in  1.
- m_axi_bresp  in  2 / m_axi_bvalid  in  1 / m_axi_bready  out  1.

Behaviour:
- One clock, clk. Reset m_aresetn is asynchronous, active-low.

Handshakes and fixed outputs:
- A byte transfers on rx_valid && rx_ready, or on tx_valid && tx_ready.
- tx_data is stable while tx_valid && !tx_ready.
- Multi-byte fields are sent and received LSB-byte first.
- arsize = awsize = clog2(DATA_BYTES). wstrb is all ones. araddr = awaddr = the address register.

Commands (first byte received in IDLE):
- 0x01 GPI_RD: capture gpi on command accept; tx GPIO_BYTES bytes.
- 0x02 GPO_RD: tx GPIO_BYTES bytes of gpo.
- 0x03 GPO_WR: rx GPIO_BYTES bytes into a shadow register. gpo updates in one cycle, the cycle after the last byte is accepted; no partial update.
- 0x04 ADDR_WR: rx 4 bytes; commit atomically, same rule as GPO_WR.
- 0x05 ADDR_RD: tx 4 bytes of the address register.
- 0x06 AXI_RD: issue AR; wait for R; tx DATA_BYTES bytes of rdata, then one status byte {6'b0, rresp}.
- 0x07 AXI_WR: rx DATA_BYTES bytes into wdata; issue AW and W; wait for B; tx status byte {6'b0, bresp}.
- 0x08 CTRL_WR: rx 1 byte; bit0 = auto-increment enable (AE). CTRL_RD is 0x09: tx {7'b0, AE}.
- Any other command byte: tx the single byte 0xEE (NAK), then return to IDLE.

States: IDLE, RX_ARG, TX_RESP, AR, R, AWW, B.
- A byte counter counts arguments/response bytes; a shift register holds the outgoing bytes.
- rx_ready = 1 only in IDLE and RX_ARG.
- TX_RESP returns to IDLE in the cycle after the last byte handshake.

AXI sequencing:
- AR: arvalid held until arready. R: rready = 1; rdata captured on rvalid.
- AWW: awvalid and wvalid both asserted on entry. Each drops independently after its own ready, including the case where both readies arrive in the same cycle. Advance to B when both have completed.
- B: bready = 1.
- No new command is accepted until the transaction and its response bytes finish.

Address auto-increment:
- When AE = 1, the address register is incremented by DATA_BYTES in the R or B handshake cycle.
- The increment applies regardless of resp value.
- 32-bit wrap: 0xFFFFFFFC + 4 = 0x00000000.

Reset values:
- State IDLE, so rx_ready = 1 immediately after reset.
- tx_valid, arvalid, awvalid, wvalid, rready, bready = 0.
- gpo = GPO_ON_RESET. Address = ADDR_ON_RESET. AE = 1. wdata = 0.

Reset mid-operation:
- Any partial argument and any pending response are discarded.
- gpo and address take their reset values, never a partial shadow value.

Test Plan:
- Reset, then 0x02 -> tx A5 A5 A5 A5. Then 0x03 11 22 33 44 -> gpo = 0x44332211 only after the 4th byte; after 3 bytes gpo is still 0xA5A5A5A5.
- 0x04 FC FF FF FF, then 0x07 DE AD BE EF; awready 3 cycles before wready; bresp = 0 -> awaddr = 0xFFFFFFFC, wdata = 0xEFBEADDE, tx 0x00. Then 0x05 -> 00 00 00 00 (wrap).
- 0x08 00, then 0x06; arready delayed 5 cycles; rdata = 0x12345678, rresp = 2 -> arvalid held for 6 cycles, tx 78 56 34 12 02; address unchanged.
- 0x06 with tx_ready low for 10 cycles per byte -> tx_valid held and tx_data stable; rx_ready = 0 throughout.
- 0x7F -> tx 0xEE; next command 0x01 with gpi = 0x0A0B0C0D -> tx 0D 0C 0B 0A.
- Assert reset after 2 of 4 GPO_WR bytes -> gpo = 0xA5A5A5A5; idle with rx_ready = 1 on release.
